// File: rtl/updown_count_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updown_arb_pkg
// Brief    : Shared types and defaults for the up/down counter arbiter.
// Revision : 1.0
// ============================================================================
package updown_arb_pkg;

    localparam int DEFAULT_BITS   = 4;
    localparam int DEFAULT_STEP_W = 4;

    localparam logic [DEFAULT_BITS-1:0] COUNT_RESET = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/updown_counter_en.sv
`default_nettype none
// ============================================================================
// Module   : updown_counter_en
// Brief    : Enabled modulo-2^BITS up/down counter, resets to all-ones.
// Revision : 1.0
// ============================================================================
module updown_counter_en
    import updown_arb_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            dir,
    output logic [BITS-1:0] count
);

    logic [BITS-1:0] count_d;
    logic [BITS-1:0] count_q;

    // Wrap-around comes for free from the fixed-width add/subtract.
    always_comb begin
        count_d = count_q;
        if (en) begin
            if (dir) begin
                count_d = count_q + {{(BITS-1){1'b0}}, 1'b1};
            end else begin
                count_d = count_q - {{(BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '1;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/updown_count_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : updown_count_arbiter
// Brief    : Round-robin arbiter granting N-step moves on a shared counter.
// Revision : 1.0
// ============================================================================
module updown_count_arbiter
    import updown_arb_pkg::*;
#(
    parameter int BITS   = DEFAULT_BITS,
    parameter int STEP_W = DEFAULT_STEP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_dir,
    input  logic [STEP_W-1:0] req_steps0,
    input  logic [STEP_W-1:0] req_steps1,
    output logic [1:0]        ack,
    output logic [1:0]        done,
    output logic              busy,
    output logic              owner,
    output logic [BITS-1:0]   count
);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_owner_q, last_owner_d;
    logic                dir_q, dir_d;
    logic [STEP_W-1:0]   remaining_q, remaining_d;
    logic [1:0]          ack_q, ack_d;
    logic [1:0]          done_q, done_d;

    logic                grant_idx;
    logic [STEP_W-1:0]   grant_steps;
    logic                cnt_en;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        dir_d        = dir_q;
        remaining_d  = remaining_q;
        ack_d        = 2'b00;
        done_d       = 2'b00;
        cnt_en       = 1'b0;

        // On a tie the requester that was not served last wins.
        grant_idx   = (req_valid == 2'b11) ? ~last_owner_q : req_valid[1];
        grant_steps = grant_idx ? req_steps1 : req_steps0;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    owner_d            = grant_idx;
                    dir_d              = req_dir[grant_idx];
                    remaining_d        = grant_steps;
                    ack_d[grant_idx]   = 1'b1;
                    if (grant_steps != '0) begin
                        state_d = RUN;
                    end else begin
                        done_d[grant_idx] = 1'b1;
                        state_d           = DONE;
                    end
                end
            end
            RUN: begin
                cnt_en      = 1'b1;
                remaining_d = remaining_q - {{(STEP_W-1){1'b0}}, 1'b1};
                if (remaining_q == {{(STEP_W-1){1'b0}}, 1'b1}) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = DONE;
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b1;
            last_owner_q <= 1'b1;
            dir_q        <= 1'b0;
            remaining_q  <= '0;
            ack_q        <= 2'b00;
            done_q       <= 2'b00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            dir_q        <= dir_d;
            remaining_q  <= remaining_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
        end
    end

    updown_counter_en #(
        .BITS (BITS)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .dir   (dir_q),
        .count (count)
    );

    assign ack   = ack_q;
    assign done  = done_q;
    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_count_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_count_arbiter
// Brief    : Directed self-checking bench for updown_count_arbiter.
// Revision : 1.0
// ============================================================================
module tb_updown_count_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_dir;
    logic [3:0] req_steps0;
    logic [3:0] req_steps1;
    logic [1:0] ack;
    logic [1:0] done;
    logic       busy;
    logic       owner;
    logic [3:0] count;

    int total = 0;
    int bad   = 0;

    updown_count_arbiter #(
        .BITS   (4),
        .STEP_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_dir    (req_dir),
        .req_steps0 (req_steps0),
        .req_steps1 (req_steps1),
        .ack        (ack),
        .done       (done),
        .busy       (busy),
        .owner      (owner),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status vector layout: {ack, done, busy, owner, count}
    task automatic test_single();
        req_dir = 2'b01; req_steps0 = 4'd3; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        total++;
        if ({ack, done, busy, owner, count} !== {2'b01, 2'b00, 1'b1, 1'b0, 4'hF}) begin
            bad++;
            $display("FAIL single_ack: got %b want %b", {ack, done, busy, owner, count}, {2'b01, 2'b00, 1'b1, 1'b0, 4'hF});
        end
        for (int i = 0; i < 3; i++) begin
            logic [1:0] exp_done;
            logic [3:0] exp_cnt;
            tick();
            exp_done = (i == 2) ? 2'b01 : 2'b00;
            exp_cnt  = 4'(i);
            total++;
            if ({ack, done, busy, count} !== {2'b00, exp_done, 1'b1, exp_cnt}) begin
                bad++;
                $display("FAIL single_step%0d: got %b want %b", i, {ack, done, busy, count}, {2'b00, exp_done, 1'b1, exp_cnt});
            end
        end
        tick();
        total++;
        if ({done, busy, count} !== {2'b00, 1'b0, 4'h2}) begin
            bad++;
            $display("FAIL single_idle: got %b want %b", {done, busy, count}, {2'b00, 1'b0, 4'h2});
        end
    endtask

    task automatic test_reset();
        req_dir = 2'b01; req_steps0 = 4'd4; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({ack, done, busy, owner, count} !== {2'b00, 2'b00, 1'b0, 1'b1, 4'hF}) begin
            bad++;
            $display("FAIL reset_async: got %b want %b", {ack, done, busy, owner, count}, {2'b00, 2'b00, 1'b0, 1'b1, 4'hF});
        end
        tick();
        reset = 1'b0;
        tick();
        total++;
        if ({ack, done, busy, owner, count} !== {2'b00, 2'b00, 1'b0, 1'b1, 4'hF}) begin
            bad++;
            $display("FAIL reset_hold: got %b want %b", {ack, done, busy, owner, count}, {2'b00, 2'b00, 1'b0, 1'b1, 4'hF});
        end
    endtask

    task automatic test_round_robin();
        req_dir = 2'b01; req_steps0 = 4'd2; req_steps1 = 4'd1; req_valid = 2'b11;
        tick();
        req_valid = 2'b10;
        total++;
        if ({ack, owner, count} !== {2'b01, 1'b0, 4'hF}) begin
            bad++;
            $display("FAIL rr_first_grant: got %b want %b", {ack, owner, count}, {2'b01, 1'b0, 4'hF});
        end
        tick();
        tick();
        total++;
        if ({done, count} !== {2'b01, 4'h1}) begin
            bad++;
            $display("FAIL rr_first_done: got %b want %b", {done, count}, {2'b01, 4'h1});
        end
        tick();
        total++;
        if ({ack, busy} !== {2'b00, 1'b0}) begin
            bad++;
            $display("FAIL rr_gap_idle: got %b want %b", {ack, busy}, {2'b00, 1'b0});
        end
        tick();
        req_valid = 2'b00;
        total++;
        if ({ack, owner, busy} !== {2'b10, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL rr_second_grant: got %b want %b", {ack, owner, busy}, {2'b10, 1'b1, 1'b1});
        end
        tick();
        total++;
        if ({done, count} !== {2'b10, 4'h0}) begin
            bad++;
            $display("FAIL rr_second_done: got %b want %b", {done, count}, {2'b10, 4'h0});
        end
        tick();
        req_valid = 2'b11;
        tick();
        req_valid = 2'b00;
        total++;
        if ({ack, owner} !== {2'b01, 1'b0}) begin
            bad++;
            $display("FAIL rr_regrant: got %b want %b", {ack, owner}, {2'b01, 1'b0});
        end
        tick();
        tick();
        total++;
        if ({done, count} !== {2'b01, 4'h2}) begin
            bad++;
            $display("FAIL rr_third_done: got %b want %b", {done, count}, {2'b01, 4'h2});
        end
        tick();
    endtask

    task automatic test_zero_steps();
        req_dir = 2'b10; req_steps1 = 4'd0; req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        total++;
        if ({ack, done, busy, owner, count} !== {2'b10, 2'b10, 1'b1, 1'b1, 4'h2}) begin
            bad++;
            $display("FAIL zero_ack_done: got %b want %b", {ack, done, busy, owner, count}, {2'b10, 2'b10, 1'b1, 1'b1, 4'h2});
        end
        tick();
        total++;
        if ({ack, done, busy, count} !== {2'b00, 2'b00, 1'b0, 4'h2}) begin
            bad++;
            $display("FAIL zero_idle: got %b want %b", {ack, done, busy, count}, {2'b00, 2'b00, 1'b0, 4'h2});
        end
    endtask

    task automatic test_abort();
        req_dir = 2'b00; req_steps0 = 4'd5; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        total++;
        if ({busy, count} !== {1'b1, 4'h0}) begin
            bad++;
            $display("FAIL abort_pre: got %b want %b", {busy, count}, {1'b1, 4'h0});
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({done, busy, owner, count} !== {2'b00, 1'b0, 1'b1, 4'hF}) begin
            bad++;
            $display("FAIL abort_reset: got %b want %b", {done, busy, owner, count}, {2'b00, 1'b0, 1'b1, 4'hF});
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if ({done, busy, count} !== {2'b00, 1'b0, 4'hF}) begin
                bad++;
                $display("FAIL abort_quiet%0d: got %b want %b", i, {done, busy, count}, {2'b00, 1'b0, 4'hF});
            end
        end
    endtask

    task automatic test_full_walk();
        req_dir = 2'b00; req_steps0 = 4'd15; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        total++;
        if ({ack, count} !== {2'b01, 4'hF}) begin
            bad++;
            $display("FAIL walk_ack: got %b want %b", {ack, count}, {2'b01, 4'hF});
        end
        for (int i = 1; i <= 15; i++) begin
            logic [1:0] exp_done;
            logic [3:0] exp_cnt;
            tick();
            exp_done = (i == 15) ? 2'b01 : 2'b00;
            exp_cnt  = 4'(15 - i);
            total++;
            if ({done, count} !== {exp_done, exp_cnt}) begin
                bad++;
                $display("FAIL walk_step%0d: got %b want %b", i, {done, count}, {exp_done, exp_cnt});
            end
        end
        tick();
        req_dir = 2'b10; req_steps1 = 4'd1; req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        total++;
        if ({ack, owner, count} !== {2'b10, 1'b1, 4'h0}) begin
            bad++;
            $display("FAIL walk_r1_ack: got %b want %b", {ack, owner, count}, {2'b10, 1'b1, 4'h0});
        end
        tick();
        total++;
        if ({done, count} !== {2'b10, 4'h1}) begin
            bad++;
            $display("FAIL walk_r1_done: got %b want %b", {done, count}, {2'b10, 4'h1});
        end
        tick();
        total++;
        if ({busy, count} !== {1'b0, 4'h1}) begin
            bad++;
            $display("FAIL walk_r1_idle: got %b want %b", {busy, count}, {1'b0, 4'h1});
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_dir    = 2'b00;
        req_steps0 = 4'd0;
        req_steps1 = 4'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        test_single();
        test_reset();
        test_round_robin();
        test_zero_steps();
        test_abort();
        test_full_walk();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
